// File: rtl/shift_seq_pkg.sv
// Shared encodings for the bc6502 shift-by-count sequencer.
package shift_seq_pkg;

    localparam logic [1:0] OP_ASL = 2'd0;
    localparam logic [1:0] OP_ROL = 2'd1;
    localparam logic [1:0] OP_LSR = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_shift_unit.sv
// Single-step ASL/ROL/LSR/ROR with 6502-style carry; in 8-bit mode only the
// low byte is meaningful and the caller restores the upper byte.
module shift_sequencer_shift_unit
    import shift_seq_pkg::*;
#(
    parameter int DBW = 16
) (
    input  logic [DBW-1:0] a,
    input  logic           ci,
    input  logic [1:0]     op,
    input  logic           sz,
    output logic [DBW-1:0] o,
    output logic           co
);

    logic fill;

    always_comb begin
        fill = op[0] ? ci : 1'b0;
        o    = a;
        co   = ci;
        if (op == OP_ASL || op == OP_ROL) begin
            o  = {a[DBW-2:0], fill};
            co = sz ? a[7] : a[DBW-1];
        end else begin
            o  = {fill, a[DBW-1:1]};
            // byte-mode right shifts enter the fill at bit 7
            if (sz) o[7] = fill;
            co = a[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-count sequencer, one bit per clock with chained carry.
// Optional N/Z flag outputs are enabled by defining SHIFT_SEQ_FLAGS_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; o/co hold the last result
// ST_SHIFT | one step per cycle while remaining != 0
// ST_DONE  | done pulse, result final
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DBW = 16
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             start,
    input  logic             sz,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt,
    input  logic             ci,
    input  logic [DBW-1:0]   a,
    output logic             busy,
    output logic             done,
    output logic [DBW-1:0]   o,
    output logic             co
`ifdef SHIFT_SEQ_FLAGS_EN
    ,
    output logic             n,
    output logic             z
`endif
);

    localparam int DMSB = DBW - 1;

    state_t           state, next_state;
    logic [1:0]       op_q;
    logic             sz_q;
    logic [CNT_W-1:0] remaining;
    logic             carry;

    logic             accept, step_en, sz_sel;
    logic [DMSB:0]    step_o, step_masked, o_nxt;
    logic             step_co;

    assign co = carry;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (start) next_state = ST_SHIFT;
            ST_SHIFT: if (remaining == '0) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    shift_sequencer_shift_unit #(.DBW(DBW)) u_step (
        .a  (o),
        .ci (carry),
        .op (op_q),
        .sz (sz_q),
        .o  (step_o),
        .co (step_co)
    );

    generate
        if (DBW > 8) begin : g_mask
            assign step_masked = sz_q ? {o[DMSB:8], step_o[7:0]} : step_o;
        end else begin : g_nomask
            assign step_masked = step_o;
        end
    endgenerate

    assign accept  = (state == ST_IDLE) && start;
    assign step_en = (state == ST_SHIFT) && (remaining != '0);
    assign o_nxt   = accept ? a : step_masked;
    assign sz_sel  = accept ? sz : sz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o         <= '0;
            carry     <= 1'b0;
            op_q      <= OP_ASL;
            sz_q      <= 1'b0;
            remaining <= '0;
        end else if (accept) begin
            o         <= a;
            carry     <= ci;
            op_q      <= op;
            sz_q      <= sz;
            remaining <= cnt;
        end else if (step_en) begin
            o         <= step_masked;
            carry     <= step_co;
            remaining <= remaining - CNT_W'(1);
        end
    end

`ifdef SHIFT_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            n <= 1'b0;
            z <= 1'b0;
        end else if (accept || step_en) begin
            n <= sz_sel ? o_nxt[7] : o_nxt[DMSB];
            z <= sz_sel ? (o_nxt[7:0] == 8'd0) : (o_nxt == '0);
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{o_nxt, sz_sel};
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer (DBW=16) with a
// closed-form reference built on (width+1)-bit carry/data concatenations.
`timescale 1ns/1ps
module tb_shift_sequencer;

    logic        rst, clk, start, sz, ci;
    logic [1:0]  op;
    logic [4:0]  cnt;
    logic [15:0] a;
    logic        busy, done, co;
    logic [15:0] o;
`ifdef SHIFT_SEQ_FLAGS_EN
    logic        n, z;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    shift_sequencer #(.DBW(16)) dut (
        .rst(rst), .clk(clk), .start(start), .sz(sz), .op(op), .cnt(cnt),
        .ci(ci), .a(a), .busy(busy), .done(done), .o(o),
`ifdef SHIFT_SEQ_FLAGS_EN
        .n(n), .z(z),
`endif
        .co(co)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of k chained steps, returned as {carry, data}.
    function automatic logic [16:0] ref_shift(input logic [15:0] av, input logic c,
                                              input logic [1:0] opv, input logic szv, input int k);
        int w, r;
        longint unsigned mask, dmask, d, v, dat;
        logic rc;
        logic [15:0] ro;
        w     = szv ? 8 : 16;
        mask  = (64'd1 << (w + 1)) - 1;
        dmask = (64'd1 << w) - 1;
        d     = szv ? 64'(av[7:0]) : 64'(av);
        r     = k % (w + 1);
        if (!opv[1]) v = (64'(c) << w) | d;   // carry sits above the MSB
        else         v = (d << 1) | 64'(c);   // carry sits below the LSB
        case (opv)
            2'd0: v = (v << k) & mask;
            2'd1: if (r != 0) v = ((v << r) | (v >> (w + 1 - r))) & mask;
            2'd2: v = v >> k;
            default: if (r != 0) v = ((v >> r) | (v << (w + 1 - r))) & mask;
        endcase
        if (!opv[1]) begin
            rc  = ((v >> w) & 64'd1) != 0;
            dat = v & dmask;
        end else begin
            rc  = (v & 64'd1) != 0;
            dat = v >> 1;
        end
        ro = szv ? {av[15:8], dat[7:0]} : dat[15:0];
        return {rc, ro};
    endfunction

    // Transaction-level model: edges since the accepting edge.
    bit          m_active = 0;
    int          m_t = 0, m_n = 0;
    logic [15:0] m_a = 0;
    logic        m_ci = 0, m_sz = 0;
    logic [1:0]  m_op = 0;
    logic [16:0] m_hold = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 0;
            m_hold   <= '0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1; m_t <= 0; m_n <= int'(cnt);
                m_a <= a; m_ci <= ci; m_op <= op; m_sz <= sz;
            end
        end else if (m_t == m_n + 1) begin
            m_active <= 0;
            m_hold   <= ref_shift(m_a, m_ci, m_op, m_sz, m_n);
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        logic e_busy, e_done;
        if (check_en) begin
            if (m_active) begin
                e      = ref_shift(m_a, m_ci, m_op, m_sz, (m_t < m_n) ? m_t : m_n);
                e_busy = 1'b1;
                e_done = (m_t == m_n + 1);
            end else begin
                e      = m_hold;
                e_busy = 1'b0;
                e_done = 1'b0;
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("o", 32'(o), 32'(e[15:0]));
            check("co", 32'(co), 32'(e[16]));
`ifdef SHIFT_SEQ_FLAGS_EN
            if (e_done) begin
                check("n", 32'(n), 32'(m_sz ? e[7] : e[15]));
                check("z", 32'(z), 32'(m_sz ? (e[7:0] == 8'd0) : (e[15:0] == 16'd0)));
            end
`endif
        end
    end

    task automatic run_cmd(input logic [1:0] op_i, input logic sz_i, input logic [4:0] cnt_i,
                           input logic [15:0] a_i, input logic ci_i, input bit lit,
                           input logic [15:0] lo, input logic lco, input bit spurious,
                           input string name);
        int edges;
        bit seen;
        start = 1; op = op_i; sz = sz_i; cnt = cnt_i; a = a_i; ci = ci_i;
        @(posedge clk); #1;
        start = 0; a = 16'($urandom); ci = 1'($urandom); op = 2'($urandom); cnt = 5'($urandom);
        edges = 0; seen = 0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1;
            else if (spurious && edges == 1) begin
                start = 1; a = 16'($urandom); cnt = 5'($urandom); op = 2'($urandom);
            end else start = 0;
        end
        start = 0;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(edges), 32'(cnt_i) + 32'd1);
        if (lit) begin
            check({name, "_o"}, 32'(o), 32'(lo));
            check({name, "_co"}, 32'(co), 32'(lco));
        end
        @(posedge clk); #1;
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [16:0] r;
        rst = 1; start = 0; sz = 0; op = 0; cnt = 0; ci = 0; a = 0;
        @(posedge clk); #1;
        check("rst_o", 32'(o), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SHIFT_SEQ_FLAGS_EN
        check("rst_n", 32'(n), 32'd0);
        check("rst_z", 32'(z), 32'd0);
`endif
        check_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // pin the reference model itself
        r = ref_shift(16'hAB81, 1'b1, 2'd2, 1'b1, 3);
        check("model_lsr8", 32'(r), {15'd0, 1'b0, 16'hAB10});
        r = ref_shift(16'h00F0, 1'b1, 2'd0, 1'b0, 20);
        check("model_asl_sat", 32'(r), 32'd0);

        run_cmd(2'd0, 1'b0, 5'd1, 16'h8001, 1'b1, 1, 16'h0002, 1'b1, 0, "asl1");
        run_cmd(2'd3, 1'b0, 5'd4, 16'h0001, 1'b0, 1, 16'h2000, 1'b0, 0, "ror4");
        run_cmd(2'd2, 1'b1, 5'd3, 16'hAB81, 1'b1, 1, 16'hAB10, 1'b0, 0, "lsr8");
        run_cmd(2'd1, 1'b0, 5'd0, 16'h1234, 1'b1, 1, 16'h1234, 1'b1, 0, "rol0");
`ifdef SHIFT_SEQ_FLAGS_EN
        check("rol0_n", 32'(n), 32'd0);
        check("rol0_z", 32'(z), 32'd0);
`endif
        run_cmd(2'd1, 1'b1, 5'd9, 16'h0055, 1'b0, 1, 16'h0055, 1'b0, 0, "rol9");
        run_cmd(2'd1, 1'b0, 5'd17, 16'hC3A5, 1'b1, 1, 16'hC3A5, 1'b1, 0, "rol17");
        run_cmd(2'd0, 1'b0, 5'd16, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 0, "asl16");
        run_cmd(2'd2, 1'b0, 5'd17, 16'hFFFF, 1'b1, 1, 16'h0000, 1'b0, 0, "lsr17");
        run_cmd(2'd0, 1'b0, 5'd3, 16'h1111, 1'b0, 1, 16'h8888, 1'b0, 1, "spurious");

        // reset mid-shift
        start = 1; op = 2'd1; sz = 0; cnt = 5'd10; a = 16'hBEEF; ci = 1;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_o", 32'(o), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        rst = 0;
        @(posedge clk); #1;
        run_cmd(2'd3, 1'b1, 5'd1, 16'h5A03, 1'b1, 1, 16'h5A81, 1'b1, 0, "after_rst");

        for (int i = 0; i < 60; i++) begin
            run_cmd(2'($urandom), 1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
                    0, 16'd0, 1'b0, bit'($urandom_range(0, 3) == 0), "rnd");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
